// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle processor control path.
// No logic; types, opcode values, state encodings and mux select codes only.
// Consumed by multicycle_ctrl and ctrl_out_decode.
package multicycle_ctrl_pkg;

  // Instruction opcodes (4-bit opcode field)
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_J     = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Controller states; encodings 12..15 are unreachable and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_WB   = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_e;

  // Datapath mux select encodings
  localparam logic       I_OR_D_PC      = 1'b0;
  localparam logic       I_OR_D_ALU     = 1'b1;
  localparam logic       REG_DST_RT     = 1'b0;
  localparam logic       REG_DST_RD     = 1'b1;
  localparam logic       MEM_TO_REG_ALU = 1'b0;
  localparam logic       MEM_TO_REG_MDR = 1'b1;
  localparam logic       ALU_A_PC       = 1'b0;
  localparam logic       ALU_A_REG      = 1'b1;
  localparam logic [1:0] ALU_B_REG      = 2'b00;
  localparam logic [1:0] ALU_B_ONE      = 2'b01;
  localparam logic [1:0] ALU_B_IMM      = 2'b10;
  localparam logic [1:0] ALU_B_BOFF     = 2'b11;
  localparam logic [1:0] ALU_OP_ADD     = 2'b00;
  localparam logic [1:0] ALU_OP_SUB     = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT   = 2'b10;
  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  // Bundle of every state-decoded datapath control
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_ctrl_out_decode.sv
// Purpose: combinational decode of controller state (+ mem_ready) to datapath controls.
// Latency: zero cycles, purely combinational.
// Backpressure: mem_ready only qualifies ir_write/pc_write in FETCH; holding is done by the FSM.
module ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode; anything not set for a state stays 0, including unreachable encodings
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = I_OR_D_PC;
        ctrl.alu_src_a = ALU_A_PC;
        ctrl.alu_src_b = ALU_B_ONE;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC load only on the cycle the fetch actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = ALU_A_PC;
        ctrl.alu_src_b = ALU_B_BOFF;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = ALU_A_REG;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = I_OR_D_ALU;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MEM_TO_REG_MDR;
        ctrl.reg_dst    = REG_DST_RT;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = I_OR_D_ALU;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = ALU_A_REG;
        ctrl.alu_src_b = ALU_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = ALU_A_REG;
        ctrl.alu_src_b     = ALU_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: main multicycle control FSM (fetch/decode/execute/memory/writeback sequencing).
// Latency: from FETCH back to FETCH with mem_ready high: R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3 cycles.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold one extra cycle for every cycle mem_ready is low.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    halted,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state_out
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  logic op_r, op_lw, op_sw, op_beq, op_j, op_addi, op_halt, op_legal;

  // zero is consumed by the datapath's pc_write_cond AND gate, not by the FSM
  logic unused_zero;
  assign unused_zero = zero;

  // Opcode classification against the full opcode field
  always_comb begin
    op_r     = (opcode == OPCODE_WIDTH'(OP_RTYPE));
    op_lw    = (opcode == OPCODE_WIDTH'(OP_LW));
    op_sw    = (opcode == OPCODE_WIDTH'(OP_SW));
    op_beq   = (opcode == OPCODE_WIDTH'(OP_BEQ));
    op_j     = (opcode == OPCODE_WIDTH'(OP_J));
    op_addi  = (opcode == OPCODE_WIDTH'(OP_ADDI));
    op_halt  = (opcode == OPCODE_WIDTH'(OP_HALT));
    op_legal = op_r | op_lw | op_sw | op_beq | op_j | op_addi | op_halt;
  end

  // Next-state logic; opcode is only looked at in DECODE and MEM_ADDR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_r)                        state_d = S_EXECUTE;
        else if (op_lw | op_sw | op_addi) state_d = S_MEM_ADDR;
        else if (op_beq)                 state_d = S_BRANCH;
        else if (op_j)                   state_d = S_JUMP;
        else if (op_halt)                state_d = S_HALT;
        else                             state_d = S_FETCH; // illegal: executes as NOP
      end
      S_MEM_ADDR: begin
        if (op_lw)        state_d = S_MEM_READ;
        else if (op_sw)   state_d = S_MEM_WRITE;
        else if (op_addi) state_d = S_ADDI_WB;
        else              state_d = S_FETCH;
      end
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_ADDI_WB:   state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH; // unreachable encodings recover
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  ctrl_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset gating: no enables or writes escape during a reset cycle
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    if (!reset) begin
      pc_write      = ctrl.pc_write;
      pc_write_cond = ctrl.pc_write_cond;
      i_or_d        = ctrl.i_or_d;
      mem_read      = ctrl.mem_read;
      mem_write     = ctrl.mem_write;
      ir_write      = ctrl.ir_write;
      mem_to_reg    = ctrl.mem_to_reg;
      reg_dst       = ctrl.reg_dst;
      reg_write     = ctrl.reg_write;
      alu_src_a     = ctrl.alu_src_a;
      alu_src_b     = ctrl.alu_src_b;
      alu_op        = ctrl.alu_op;
      pc_source     = ctrl.pc_source;
      halted        = ctrl.halted;
      illegal_op    = (state_q == S_DECODE) && !op_legal;
    end
  end

  assign state_out = STATE_WIDTH'(state_q);

endmodule
